// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller: RV32I load/store size codes and FSM states.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Illegal size code for the operation, or an access not aligned to its size.
    function automatic logic access_err(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic bad_code;
        logic misaligned;
        if (is_store)
            bad_code = (f3 > F3_SW);
        else
            bad_code = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
        return bad_code || misaligned;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and data replication, load lane extraction and extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        be        = '0;
        wdata_rep = '0;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = '1;
                wdata_rep = wdata;
            end
        endcase
    end

    always_comb begin
        shifted   = rword >> {addr_lo, 3'b000};
        rdata_ext = '0;
        case (funct3)
            F3_LB:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   rdata_ext = rword;
            F3_LBU:  rdata_ext = {24'd0, shifted[7:0]};
            F3_LHU:  rdata_ext = {16'd0, shifted[15:0]};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: accepts one load/store at a time, inserts WAIT_CYCLES wait
// states, then completes with a one-cycle ready pulse (err flags illegal/misaligned access).
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic [AW+1:0] addr_q;
    logic [2:0]    f3_q;
    logic [31:0]   wdata_q;
    logic          op_wr;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic [AW+1:0] cur_addr;
    logic [2:0]    cur_f3;
    logic [31:0]   cur_wdata;
    logic          cur_wr;
    logic          cur_err;
    logic          finish;
    logic          mem_we;
    logic [AW-1:0] idx;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [31:0]   load_ext;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^addr[31:AW+2];

    // With zero wait states or an error, completion happens on the accept edge itself,
    // so the datapath takes the live inputs in IDLE and the latched request otherwise.
    assign accept    = (state == ST_IDLE) && !cs_n && (rd ^ wr);
    assign cur_addr  = (state == ST_IDLE) ? addr[AW+1:0] : addr_q;
    assign cur_f3    = (state == ST_IDLE) ? funct3 : f3_q;
    assign cur_wdata = (state == ST_IDLE) ? wdata : wdata_q;
    assign cur_wr    = (state == ST_IDLE) ? wr : op_wr;
    assign cur_err   = access_err(cur_wr, cur_f3, cur_addr[1:0]);
    assign finish    = (accept && (cur_err || (WAIT_CYCLES == 0))) ||
                       ((state == ST_WAIT) && (cnt == 4'd0));
    assign mem_we    = finish && cur_wr && !cur_err && !rst;
    assign idx       = cur_addr[AW+1:2];
    assign rword     = mem[idx];

    mem_lane_align u_align (
        .addr_lo   (cur_addr[1:0]),
        .funct3    (cur_f3),
        .wdata     (cur_wdata),
        .rword     (rword),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (load_ext)
    );

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= '0;
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            op_wr   <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q  <= addr[AW+1:0];
                        f3_q    <= funct3;
                        wdata_q <= wdata;
                        op_wr   <= wr;
                        busy    <= 1'b1;
                        cnt     <= WAIT_INIT;
                        state   <= (cur_err || (WAIT_CYCLES == 0)) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0)
                        state <= ST_RESP;
                    else
                        cnt <= cnt - 4'd1;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
            if (finish) begin
                ready <= 1'b1;
                err   <= cur_err;
                if (cur_err)
                    rdata <= '0;
                else if (!cur_wr)
                    rdata <= load_ext;
            end
        end
    end

endmodule
